// File: rtl/amds_sample_sched_if.sv
// amds_sample_sched_if: trigger, receiver and status signals of the AMDS sample scheduler
interface amds_sample_sched_if;
  logic        enable;
  logic        trigger;
  logic        rx_done0;
  logic        rx_done1;
  logic [3:0]  valid0;
  logic [3:0]  valid1;
  logic        sync_adc;
  logic        start_rx0;
  logic        start_rx1;
  logic        busy;
  logic        sample_done;
  logic [7:0]  valid_mask;
  logic        all_valid;
  logic        wdog_timeout;
  logic [15:0] count_sequences;
  logic [15:0] count_trig_missed;
  logic [15:0] count_wdog;
  modport master (
    output enable, trigger, rx_done0, rx_done1, valid0, valid1,
    input  sync_adc, start_rx0, start_rx1, busy, sample_done, valid_mask, all_valid,
    input  wdog_timeout, count_sequences, count_trig_missed, count_wdog
  );
  modport slave (
    input  enable, trigger, rx_done0, rx_done1, valid0, valid1,
    output sync_adc, start_rx0, start_rx1, busy, sample_done, valid_mask, all_valid,
    output wdog_timeout, count_sequences, count_trig_missed, count_wdog
  );
endinterface

// File: rtl/amds_sample_sched.sv
// amds_sample_sched: per-trigger AMDS sync/start sequencer; WAIT watchdog enabled by AMDS_WDOG_EN
module amds_sample_sched #(
  parameter int SYNC_PULSE_CYCLES  = 100,
  parameter int START_DELAY_CYCLES = 50,
  parameter int WDOG_CYCLES        = 20000
) (
  input logic               clk,
  input logic               rst_n,
  amds_sample_sched_if.slave bus
);
  localparam int MAX_SD = SYNC_PULSE_CYCLES > START_DELAY_CYCLES ? SYNC_PULSE_CYCLES : START_DELAY_CYCLES;
  localparam int MAX_C  = MAX_SD > WDOG_CYCLES ? MAX_SD : WDOG_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);
  typedef enum logic [2:0] {IDLE, SYNC, DELAY, START, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sync_q, start_q, busy_q, done_q, all_valid_q;
  logic [7:0] mask_q;
  logic [15:0] seq_q, miss_q;
  logic rx_ok, wdog_hit;
  // cnt_q is zero only in the first WAIT cycle, when receivers may still report the old done
  assign rx_ok = bus.rx_done0 & bus.rx_done1 & (cnt_q != '0);
`ifdef AMDS_WDOG_EN
  logic wdog_q;
  logic [15:0] wdog_cnt_q;
  assign wdog_hit = !rx_ok && state_q == WAIT && cnt_q == CW'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wdog_q     <= 1'b0;
      wdog_cnt_q <= '0;
    end else begin
      wdog_q     <= wdog_hit;
      wdog_cnt_q <= wdog_hit ? wdog_cnt_q + 16'd1 : wdog_cnt_q;
    end
  assign bus.wdog_timeout = wdog_q;
  assign bus.count_wdog   = wdog_cnt_q;
`else
  assign wdog_hit         = 1'b0;
  assign bus.wdog_timeout = 1'b0;
  assign bus.count_wdog   = '0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:  state_d = (bus.enable && bus.trigger) ? SYNC : IDLE;
      SYNC:  if (cnt_q == CW'(SYNC_PULSE_CYCLES - 1)) state_d = DELAY;
             else cnt_d = cnt_q + CW'(1);
      DELAY: if (cnt_q == CW'(START_DELAY_CYCLES - 1)) state_d = START;
             else cnt_d = cnt_q + CW'(1);
      START: state_d = WAIT;
      WAIT:  if (rx_ok || wdog_hit) state_d = DONE;
             else cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sync_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mask_q      <= '0;
      all_valid_q <= 1'b0;
      seq_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= state_d == SYNC;
      start_q <= state_d == START;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      if (state_d == DONE) begin
        mask_q      <= {bus.valid1, bus.valid0};
        all_valid_q <= &{bus.valid1, bus.valid0};
        seq_q       <= seq_q + 16'd1;
      end
      if (state_q != IDLE && bus.enable && bus.trigger) miss_q <= miss_q + 16'd1;
    end
  assign bus.sync_adc          = sync_q;
  assign bus.start_rx0         = start_q;
  assign bus.start_rx1         = start_q;
  assign bus.busy              = busy_q;
  assign bus.sample_done       = done_q;
  assign bus.valid_mask        = mask_q;
  assign bus.all_valid         = all_valid_q;
  assign bus.count_sequences   = seq_q;
  assign bus.count_trig_missed = miss_q;
endmodule

// File: tb/tb_amds_sample_sched.sv
// tb_amds_sample_sched: directed checks of trigger timing, masks, missed-trigger counting and reset
module tb_amds_sample_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int t_sync, n_sync, t_start, n_start, t_done, n_done, t_wdog, split;
  logic [7:0] mask_mid;
  amds_sample_sched_if bus();
  amds_sample_sched #(.SYNC_PULSE_CYCLES(100), .START_DELAY_CYCLES(50), .WDOG_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // index i = negedge following posedge E0+i; receivers drop done from i=152 and raise it at 151+lat
  task automatic seq(input bit en, input int lat, input logic [3:0] v0, input logic [3:0] v1,
                     input bit stuck1, input int len, input int t0, input int t1, input int t2,
                     input int t3, input int t4, input int en_off);
    t_sync = -1; n_sync = 0; t_start = -1; n_start = 0;
    t_done = -1; n_done = 0; t_wdog = -1; split = 0; mask_mid = 8'h00;
    bus.enable = en;
    bus.trigger = 1'b1;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      if (bus.sync_adc) begin n_sync++; if (t_sync < 0) t_sync = i; end
      if (bus.start_rx0 && bus.start_rx1) begin n_start++; if (t_start < 0) t_start = i; end
      if (bus.start_rx0 != bus.start_rx1) split++;
      if (bus.sample_done) begin n_done++; if (t_done < 0) t_done = i; end
      if (bus.wdog_timeout && t_wdog < 0) t_wdog = i;
      if (i == 200) mask_mid = bus.valid_mask;
      bus.rx_done0 = !(i >= 152 && i < 151 + lat);
      bus.rx_done1 = stuck1 ? (i < 152) : bus.rx_done0;
      bus.valid0 = (i >= 151 + lat) ? v0 : 4'h0;
      bus.valid1 = (i >= 151 + lat) ? v1 : 4'h0;
      bus.trigger = (i == t0) || (i == t1) || (i == t2) || (i == t3) || (i == t4);
      if (en_off >= 0 && i >= en_off) bus.enable = 1'b0;
      @(negedge clk);
    end
    bus.trigger = 1'b0;
  endtask
  initial begin
    bus.enable = 1'b0; bus.trigger = 1'b0;
    bus.rx_done0 = 1'b1; bus.rx_done1 = 1'b1;
    bus.valid0 = 4'h0; bus.valid1 = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_sync", bus.sync_adc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_seq", bus.count_sequences, 0);
    chk("rst_mask", bus.valid_mask, 0);
    rst_n = 1'b1;
    @(negedge clk);
    seq(1, 300, 4'hF, 4'hF, 0, 500, -1, -1, -1, -1, -1, -1);
    chk("t1_sync_first", t_sync, 0);
    chk("t1_sync_len", n_sync, 100);
    chk("t1_start_at", t_start, 150);
    chk("t1_start_len", n_start, 1);
    chk("t1_start_split", split, 0);
    chk("t1_done_at", t_done, 452);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_mask", bus.valid_mask, 8'hFF);
    chk("t1_all_valid", bus.all_valid, 1);
    chk("t1_seq", bus.count_sequences, 1);
    chk("t1_missed", bus.count_trig_missed, 0);
    chk("t1_busy_end", bus.busy, 0);
    chk("t1_wdog_cnt", bus.count_wdog, 0);
    seq(1, 300, 4'hF, 4'h5, 0, 500, -1, -1, -1, -1, -1, -1);
    chk("t2_mask_held", mask_mid, 8'hFF);
    chk("t2_mask", bus.valid_mask, 8'h5F);
    chk("t2_all_valid", bus.all_valid, 0);
    chk("t2_seq", bus.count_sequences, 2);
    seq(1, 300, 4'hF, 4'hF, 0, 460, 200, 250, 300, 452, 453, -1);
    chk("t3_missed", bus.count_trig_missed, 4);
    chk("t3_done_cnt", n_done, 1);
    chk("t3_seq", bus.count_sequences, 3);
    chk("t3_mask", bus.valid_mask, 8'hFF);
    chk("t3_restart_sync", bus.sync_adc, 1);
    chk("t3_restart_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_sync", bus.sync_adc, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_seq", bus.count_sequences, 0);
    chk("rst_mid_missed", bus.count_trig_missed, 0);
    chk("rst_mid_mask", bus.valid_mask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    seq(0, 300, 4'hF, 4'hF, 0, 300, 50, 100, -1, -1, -1, -1);
    chk("t4_no_sync", n_sync, 0);
    chk("t4_seq", bus.count_sequences, 0);
    chk("t4_missed", bus.count_trig_missed, 0);
    chk("t4_busy", bus.busy, 0);
    seq(1, 300, 4'hF, 4'hF, 0, 500, 470, -1, -1, -1, -1, 120);
    chk("t5_start_at", t_start, 150);
    chk("t5_done_cnt", n_done, 1);
    chk("t5_seq", bus.count_sequences, 1);
    chk("t5_missed", bus.count_trig_missed, 0);
    chk("t5_busy_end", bus.busy, 0);
    seq(1, 300, 4'hF, 4'h3, 1, 1200, -1, -1, -1, -1, -1, -1);
`ifdef AMDS_WDOG_EN
    chk("t6_done_at", t_done, 1151);
    chk("t6_wdog_at", t_wdog, 1151);
    chk("t6_wdog_cnt", bus.count_wdog, 1);
    chk("t6_seq", bus.count_sequences, 2);
    chk("t6_mask", bus.valid_mask, 8'h3F);
    chk("t6_busy_end", bus.busy, 0);
`else
    chk("t6_done_cnt", n_done, 0);
    chk("t6_busy_stuck", bus.busy, 1);
    chk("t6_wdog_pulse", t_wdog, -1);
    chk("t6_wdog_cnt", bus.count_wdog, 0);
    chk("t6_seq", bus.count_sequences, 1);
`endif
    rst_n = 1'b0;
    bus.rx_done1 = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", bus.busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
